// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCAL,
    S_DDR_CMD,
    S_DDR_WAIT,
    S_ACK
  } mem_arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } mem_arb_req_t;

  localparam logic [31:0] TIMEOUT_DATA     = 32'hDEADBEEF;
  localparam logic [29:0] DDR_BASE_DEFAULT = 30'h1000;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0]   req_i,   // [0] fetch, [1] data
  input  mem_arb_req_t last_i,
  output mem_arb_req_t grant_o
);

  always_comb begin
    grant_o = REQ_IF;
    if (req_i == 2'b11) grant_o = (last_i == REQ_IF) ? REQ_D : REQ_IF;
    else if (req_i[1])  grant_o = REQ_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data requesters (SRAM/disk fixed
// latency, LPDDR2 handshaked). MEM_ARB_TIMEOUT_EN adds an LPDDR2 watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [29:0] DDR_BASE       = DDR_BASE_DEFAULT,
  parameter int unsigned LOCAL_LAT      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  output logic        mem_rren,
  input  logic [31:0] mem_rdata,
  input  logic        ddr_ready,
  input  logic        ddr_rvalid,
  output logic        busy,
  output logic        timeout_err
);

  mem_arb_state_t state_q, state_d;
  mem_arb_req_t   gnt_q, gnt_d, last_q, last_d, rr_gnt;
  logic        we_q, we_d, wren_q, wren_d, rren_q, rren_d;
  logic        if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0]  lcnt_q, lcnt_d;
  logic        fin, cap;
  logic [31:0] fin_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           tmo_q, tmo_d;
`else
  // Parameter kept so both builds instantiate identically.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  mem_arb_rr u_rr (
    .req_i   ({d_req, if_req}),
    .last_i  (last_q),
    .grant_o (rr_gnt)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wren_d     = wren_q;
    rren_d     = rren_q;
    lcnt_d     = lcnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    fin        = 1'b0;
    cap        = 1'b0;
    fin_data   = mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    tmo_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (if_req || d_req) begin
        gnt_d = rr_gnt;
        if (rr_gnt == REQ_IF) begin
          addr_d = if_addr;
          we_d   = 1'b0;
        end else begin
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
        end
        wren_d = we_d;
        rren_d = !we_d;
        if (addr_d < DDR_BASE) begin
          state_d = S_LOCAL;
          lcnt_d  = 2'(LOCAL_LAT - 1);
        end else begin
          state_d = S_DDR_CMD;
`ifdef MEM_ARB_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      S_LOCAL: begin
        // Local devices take a single-cycle strobe, then return data at LOCAL_LAT.
        wren_d = 1'b0;
        rren_d = 1'b0;
        if (lcnt_q == 2'd0) begin
          fin = 1'b1;
          cap = !we_q;
        end else begin
          lcnt_d = lcnt_q - 2'd1;
        end
      end
      S_DDR_CMD: if (ddr_ready) begin
        wren_d = 1'b0;
        rren_d = 1'b0;
        if (we_q) fin = 1'b1;
        else      state_d = S_DDR_WAIT;
      end
      S_DDR_WAIT: if (ddr_rvalid) begin
        fin = 1'b1;
        cap = 1'b1;
      end
      S_ACK: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MEM_ARB_TIMEOUT_EN
    if ((state_q == S_DDR_CMD) || (state_q == S_DDR_WAIT)) begin
      tcnt_d = tcnt_q + 1'b1;
      if (!fin && (tcnt_q == TCW'(TIMEOUT_CYCLES - 1))) begin
        fin      = 1'b1;
        cap      = !we_q;
        fin_data = TIMEOUT_DATA;
        wren_d   = 1'b0;
        rren_d   = 1'b0;
        tmo_d    = 1'b1;
      end
    end
`endif

    if (fin) begin
      state_d = S_ACK;
      if (gnt_q == REQ_IF) begin
        if_ack_d = 1'b1;
        if (cap) if_rdata_d = fin_data;
      end else begin
        d_ack_d = 1'b1;
        if (cap) d_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= REQ_D;
      last_q     <= REQ_D;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      rren_q     <= 1'b0;
      lcnt_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tcnt_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wren_q     <= wren_d;
      rren_q     <= rren_d;
      lcnt_q     <= lcnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wren  = wren_q;
  assign mem_rren  = rren_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign busy      = (state_q != S_IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the watchdog case runs only
// when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, ddr_ready, ddr_rvalid;
  logic [29:0] if_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [29:0] mem_addr;
  logic        if_ack, d_ack, mem_wren, mem_rren, busy, timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(
    .DDR_BASE       (30'h1000),
    .LOCAL_LAT      (1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wren    (mem_wren),
    .mem_rren    (mem_rren),
    .mem_rdata   (mem_rdata),
    .ddr_ready   (ddr_ready),
    .ddr_rvalid  (ddr_rvalid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    ddr_ready = 1'b0; ddr_rvalid = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("reset_ctl", {28'd0, busy, if_ack, d_ack, timeout_err}, 32'd0);
    chk("reset_strb", {30'd0, mem_wren, mem_rren}, 32'd0);
    chk("reset_addr", {2'b0, mem_addr}, 32'd0);
    chk("reset_rdata", if_rdata | d_rdata | mem_wdata, 32'd0);

    // Reset while waiting for LPDDR2 read data; the late response is dropped.
    rst = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h2000;
    tick();
    chk("rm_rren", {31'd0, mem_rren}, 32'd1);
    chk("rm_addr", {2'b0, mem_addr}, 32'h2000);
    ddr_ready = 1'b1;
    tick();
    ddr_ready = 1'b0;
    chk("rm_wait_rren", {31'd0, mem_rren}, 32'd0);
    chk("rm_wait_busy", {31'd0, busy}, 32'd1);
    tick();
    rst = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b1; ddr_rvalid = 1'b1; mem_rdata = 32'h55;
    tick();
    chk("rm_noack", {30'd0, d_ack, busy}, 32'd0);
    chk("rm_rdata", d_rdata, 32'd0);
    ddr_rvalid = 1'b0;
    tick();
    chk("rm_noack2", {29'd0, d_ack, if_ack, busy}, 32'd0);

    // Local fetch read, LOCAL_LAT=1.
    if_req = 1'b1; if_addr = 30'h010; mem_rdata = 32'h12345678;
    tick();
    chk("lf_rren", {31'd0, mem_rren}, 32'd1);
    chk("lf_addr", {2'b0, mem_addr}, 32'h010);
    chk("lf_ack_early", {31'd0, if_ack}, 32'd0);
    tick();
    chk("lf_ack", {30'd0, if_ack, mem_rren}, 32'd2);
    chk("lf_rdata", if_rdata, 32'h12345678);
    if_req = 1'b0;
    tick();
    chk("lf_idle", {30'd0, if_ack, busy}, 32'd0);
    chk("lf_rdata_hold", if_rdata, 32'h12345678);

    // Contention from a fresh reset: fetch wins first tie, then alternate.
    rst = 1'b0; tick(); rst = 1'b1;
    if_addr = 30'h020; d_addr = 30'h030; d_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_req = 1'b1; d_req = 1'b1; mem_rdata = 32'h100 + i;
      tick();
      chk("rr_addr", {2'b0, mem_addr}, (i % 2 == 0) ? 32'h020 : 32'h030);
      tick();
      chk("rr_ack", {30'd0, if_ack, d_ack}, (i % 2 == 0) ? 32'd2 : 32'd1);
      chk("rr_rdata", (i % 2 == 0) ? if_rdata : d_rdata, 32'h100 + i);
      if (i % 2 == 0) if_req = 1'b0; else d_req = 1'b0;
      tick();
      chk("rr_ack_drop", {30'd0, if_ack, d_ack}, 32'd0);
    end
    if_req = 1'b0;

    // LPDDR2 write, ready in the fifth strobe cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h1004; d_wdata = 32'hCAFEF00D;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("dw_wren", {31'd0, mem_wren}, 32'd1);
      chk("dw_addr", {2'b0, mem_addr}, 32'h1004);
    end
    chk("dw_wdata", mem_wdata, 32'hCAFEF00D);
    ddr_ready = 1'b1;
    tick();
    ddr_ready = 1'b0;
    chk("dw_ack", {30'd0, d_ack, mem_wren}, 32'd2);
    chk("dw_rdata_keep", d_rdata, 32'h103);
    d_req = 1'b0;
    tick();
    chk("dw_ack_drop", {31'd0, d_ack}, 32'd0);

    // LPDDR2 read: ready in cycle 2, rvalid in cycle 7, ack in cycle 8.
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h2000;
    tick();
    chk("dr_rren", {31'd0, mem_rren}, 32'd1);
    tick();
    ddr_ready = 1'b1;
    tick();
    ddr_ready = 1'b0;
    chk("dr_rren_drop", {31'd0, mem_rren}, 32'd0);
    for (int c = 4; c <= 7; c++) begin
      tick();
      chk("dr_wait", {31'd0, d_ack}, 32'd0);
    end
    ddr_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    ddr_rvalid = 1'b0;
    chk("dr_ack", {31'd0, d_ack}, 32'd1);
    chk("dr_rdata", d_rdata, 32'hA5A5A5A5);
    d_req = 1'b0;
    tick();

    // Ready and rvalid together in DDR_CMD: rvalid must be ignored.
    d_req = 1'b1; d_addr = 30'h3000;
    tick();
    ddr_ready = 1'b1; ddr_rvalid = 1'b1; mem_rdata = 32'h11;
    tick();
    ddr_ready = 1'b0; ddr_rvalid = 1'b0;
    chk("rv_ign_ack", {31'd0, d_ack}, 32'd0);
    tick();
    chk("rv_ign_ack2", {31'd0, d_ack}, 32'd0);
    ddr_rvalid = 1'b1; mem_rdata = 32'h22;
    tick();
    ddr_rvalid = 1'b0;
    chk("rv_ack", {31'd0, d_ack}, 32'd1);
    chk("rv_rdata", d_rdata, 32'h22);
    d_req = 1'b0;
    tick();

    // Local (disk) write leaves rdata untouched.
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h800; d_wdata = 32'h0BADF00D;
    tick();
    chk("lw_wren", {30'd0, mem_wren, mem_rren}, 32'd2);
    tick();
    chk("lw_ack", {30'd0, d_ack, mem_wren}, 32'd2);
    chk("lw_rdata_keep", d_rdata, 32'h22);
    d_req = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no ddr_ready for 16 cycles forces a timeout ack.
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h1000;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("to_wait", {30'd0, d_ack, timeout_err}, 32'd0);
    end
    tick();
    chk("to_ack", {29'd0, d_ack, timeout_err, mem_rren}, 32'd6);
    chk("to_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0;
    tick();
    chk("to_pulse", {31'd0, timeout_err}, 32'd0);
`else
    // Without the watchdog an LPDDR2 read waits indefinitely.
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h1000;
    for (int c = 1; c <= 20; c++) tick();
    chk("nt_wait", {29'd0, d_ack, timeout_err, mem_rren}, 32'd1);
    ddr_ready = 1'b1;
    tick();
    ddr_ready = 1'b0; ddr_rvalid = 1'b1; mem_rdata = 32'h77;
    tick();
    ddr_rvalid = 1'b0;
    chk("nt_ack", {30'd0, d_ack, timeout_err}, 32'd2);
    chk("nt_rdata", d_rdata, 32'h77);
    d_req = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the single CPU-side memory port (word address / write data / wren / rren, with 0x000–0x7FF SRAM, 0x800–0xFFF disk, ≥0x1000 LPDDR2) between the instruction-fetch and data requesters. Grants one requester at a time with round-robin fairness. Drives fixed-latency local accesses (SRAM/disk) and variable-latency LPDDR2 accesses, and returns read data with a one-cycle ack pulse per requester.

## Interface
- DDR_BASE, 30'h1000, first word address routed to LPDDR2 (variable latency)
- LOCAL_LAT, 1, read latency in cycles of SRAM/disk, 1–4
- TIMEOUT_CYCLES, 1024, LPDDR2 watchdog limit (used only with the macro)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request (read-only), held until if_ack
- if_addr  in  30  fetch word address
- if_rdata  out  32  fetch read data, valid while if_ack=1, held until the next fetch ack
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  30  data word address
- d_wdata  in  32  data write value
- d_rdata  out  32  data read data, valid while d_ack=1, held until the next data ack
- d_ack  out  1  one-cycle completion pulse
- mem_addr  out  30  to memory port
- mem_wdata  out  32  to memory port
- mem_wren  out  1  write strobe (drives E·wren)
- mem_rren  out  1  read strobe
- mem_rdata  in  32  memory port read data
- ddr_ready  in  1  LPDDR2 accepted current command
- ddr_rvalid  in  1  LPDDR2 read data valid on mem_rdata
- busy  out  1  state ≠ IDLE
- timeout_err  out  1  one-cycle LPDDR2 timeout pulse

## Operation
- States: IDLE, LOCAL, DDR_CMD, DDR_WAIT, ACK.
- IDLE: if any req is high, pick a grantee:
  - only one requesting → that one;
  - both requesting → the one not granted last (last_grant resets to data, so fetch wins the first tie).
- IDLE registers the grantee's addr/we/wdata into mem_addr/mem_wdata.
  - mem_addr < DDR_BASE → LOCAL.
  - otherwise → DDR_CMD.
  - Fetch is always a read.
- LOCAL: strobe (mem_wren or mem_rren) high for the first cycle only; stays LOCAL_LAT cycles.
  - On exit, mem_rdata is captured into the grantee's rdata (reads only) → ACK.
- DDR_CMD: strobe held high until ddr_ready=1 is sampled.
  - write → ACK.
  - read → DDR_WAIT (strobe drops).
- DDR_WAIT: on ddr_rvalid=1, capture mem_rdata → ACK.
  - ddr_rvalid in any other state is ignored.
- ACK: grantee's ack=1 for exactly one cycle; last_grant updated; → IDLE.
- Requester contract:
  - req/addr/we/wdata are stable from assertion until ack.
  - A req still high at the end of the IDLE cycle after ack is a new request.
- Writes leave rdata unchanged.
- Simultaneous ddr_ready and ddr_rvalid in DDR_CMD: ready is taken; rvalid ignored.
- Reset (rst=0) at any point:
  - next state IDLE; mem_wren/mem_rren/acks/busy/timeout_err=0;
  - rdata registers, mem_addr, mem_wdata=0; last_grant=data.
  - An in-flight LPDDR2 response is dropped.

## Timing
- Reset values: every output 0.
- Local access, request sampled in IDLE at edge N:
  - strobe high in cycle N+1;
  - ack high in cycle N+1+LOCAL_LAT;
  - IDLE again at N+2+LOCAL_LAT.
- LOCAL_LAT=1: 3-cycle request-to-IDLE turnaround.
- LPDDR2: ack is one cycle after ddr_ready (write) or ddr_rvalid (read).
- Strobes, mem_addr and mem_wdata are registered outputs; no combinational path from req to the memory port.
- Back-to-back contention: grants alternate fetch/data each transaction.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - a counter runs in DDR_CMD/DDR_WAIT and clears on entry to DDR_CMD;
  - reaching TIMEOUT_CYCLES → ACK with rdata=32'hDEADBEEF (reads), timeout_err pulses together with ack, strobe dropped.
- Undefined: no counter; LPDDR2 waits are unbounded; timeout_err tied 0.

## Structure
- Package mem_arb_pkg:
  - state enum mem_arb_state_t;
  - requester id enum (REQ_IF, REQ_D);
  - TIMEOUT_DATA = 32'hDEADBEEF;
  - default DDR_BASE.
- Sub-module mem_arb_rr: 2-way round-robin picker (req vector + last_grant in, grant id out, purely combinational).
- FSM, datapath registers and timeout counter stay in mem_arbiter.

## Test plan
- Reset mid DDR_WAIT, then ddr_rvalid=1 after reset release → no ack, busy=0, outputs 0.
- Fetch read 0x010 with mem_rdata=0x12345678, LOCAL_LAT=1 → mem_rren one cycle; if_ack 2 cycles after sampling; if_rdata=0x12345678.
- Fetch and data requests asserted in the same cycle, repeated 4 times → grants IF, D, IF, D; each ack single-cycle.
- Data write 0x1004=0xCAFEF00D, ddr_ready after 5 cycles → mem_wren held 5 cycles with mem_addr=0x1004; d_ack next cycle; d_rdata unchanged.
- Data read 0x2000, ddr_ready at cycle 2, ddr_rvalid at cycle 7 with 0xA5A5A5A5 → d_ack cycle 8; d_rdata=0xA5A5A5A5.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: read 0x1000, ddr_ready never asserted → d_ack and timeout_err together; d_rdata=0xDEADBEEF.
